// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the 4-way burst arbiter and its data-path mux.
// The round-robin search helper lives here so the arbiter top stays FSM-only.
package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    // First requester with req high, searching ptr, ptr+1, ... wrapping modulo NUM_REQ.
    function automatic logic [SEL_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] req,
        input logic [SEL_W-1:0]   ptr
    );
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] idx;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = ptr + SEL_W'(i);
            if (!found && req[idx]) begin
                pick  = idx;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/mux4_arb_if.sv
// Requester/downstream bundle of the 4-way arbiter. The arbiter uses the slave
// view; whoever drives requests and consumes s uses the master view.
interface mux4_arb_if #(
    parameter int WIDTH = 8
);
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   e0;
    logic [WIDTH-1:0]   e1;
    logic [WIDTH-1:0]   e2;
    logic [WIDTH-1:0]   e3;
    logic               s_ready;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               en;
    logic [WIDTH-1:0]   s;
    logic               s_valid;

    modport master (
        output req, e0, e1, e2, e3, s_ready,
        input  gnt, sel, en, s, s_valid
    );

    modport slave (
        input  req, e0, e1, e2, e3, s_ready,
        output gnt, sel, en, s, s_valid
    );

endinterface

// File: rtl/mux4_arb_mux4.sv
// Gated 4:1 data mux: s follows the selected input while en is high, else zero.
module mux4
    import mux_arb_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             en,
    input  logic [SEL_W-1:0] sel,
    input  logic [WIDTH-1:0] e0,
    input  logic [WIDTH-1:0] e1,
    input  logic [WIDTH-1:0] e2,
    input  logic [WIDTH-1:0] e3,
    output logic [WIDTH-1:0] s
);

    always_comb begin
        s = '0;
        if (en) begin
            case (sel)
                2'd0:    s = e0;
                2'd1:    s = e1;
                2'd2:    s = e2;
                default: s = e3;
            endcase
        end
    end

endmodule

// File: rtl/mux4_arb.sv
// Round-robin 4-way burst arbiter: grants one requester for up to MAX_BURST beats,
// then always drops to IDLE for one cycle before the next arbitration.
module mux4_arb
    import mux_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic       clk,
    input  logic       rst,
    mux4_arb_if.slave  bus
);

    localparam logic [7:0] LAST_BEAT = 8'(MAX_BURST - 1);

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic [7:0]       beat_reg, beat_next;
    logic             en;
    logic             s_valid;
    logic             xfer;

    assign en      = (state_reg == BUSY);
    assign s_valid = en && bus.req[sel_reg];
    assign xfer    = s_valid && bus.s_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            sel_reg   <= '0;
            ptr_reg   <= '0;
            beat_reg  <= '0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            ptr_reg   <= ptr_next;
            beat_reg  <= beat_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        ptr_next   = ptr_reg;
        beat_next  = beat_reg;
        case (state_reg)
            IDLE: begin
                if (|bus.req) begin
                    sel_next   = rr_pick(bus.req, ptr_reg);
                    beat_next  = '0;
                    state_next = BUSY;
                end
            end
            BUSY: begin
                if (xfer) begin
                    beat_next = beat_reg + 8'd1;
                end
                // A final-beat transfer and a dropped request both release; either way ptr advances.
                if ((xfer && (beat_reg == LAST_BEAT)) || !bus.req[sel_reg]) begin
                    state_next = IDLE;
                    ptr_next   = sel_reg + SEL_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_gnt
            assign bus.gnt[gi] = en && (sel_reg == SEL_W'(gi));
        end
    endgenerate

    assign bus.sel     = sel_reg;
    assign bus.en      = en;
    assign bus.s_valid = s_valid;

    mux4 #(
        .WIDTH (WIDTH)
    ) u_mux4 (
        .en  (en),
        .sel (sel_reg),
        .e0  (bus.e0),
        .e1  (bus.e1),
        .e2  (bus.e2),
        .e3  (bus.e3),
        .s   (bus.s)
    );

endmodule

// File: tb/tb_mux4_arb.sv
// Drives two arbiters (MAX_BURST 4 and 1) with identical stimulus and checks every
// output each cycle against a grant/beat-counting reference model.
module tb_mux4_arb;
    import mux_arb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] req_d = '0;
    logic       rdy_d = 1'b0;
    logic [7:0] e_d [4];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state per instance: owner = -1 when no grant is active.
    int  owner [2];
    int  ptr_m [2];
    int  sel_m [2];
    int  beats [2];
    int  mb    [2];
    bit  model_ok = 1'b0;
    logic [3:0] last_gnt_a;

    logic [3:0] exp029 [7];

    always #5 clk = ~clk;

    mux4_arb_if #(.WIDTH(8)) bus_a ();
    mux4_arb_if #(.WIDTH(8)) bus_b ();

    assign bus_a.req = req_d;  assign bus_b.req = req_d;
    assign bus_a.s_ready = rdy_d;  assign bus_b.s_ready = rdy_d;
    assign bus_a.e0 = e_d[0];  assign bus_b.e0 = e_d[0];
    assign bus_a.e1 = e_d[1];  assign bus_b.e1 = e_d[1];
    assign bus_a.e2 = e_d[2];  assign bus_b.e2 = e_d[2];
    assign bus_a.e3 = e_d[3];  assign bus_b.e3 = e_d[3];

    mux4_arb #(.WIDTH(8), .MAX_BURST(4)) dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    mux4_arb #(.WIDTH(8), .MAX_BURST(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                owner[k] = -1; ptr_m[k] = 0; sel_m[k] = 0; beats[k] = 0;
            end else if (owner[k] < 0) begin
                for (int i = 0; i < 4; i++) begin
                    int idx;
                    idx = (ptr_m[k] + i) % 4;
                    if (owner[k] < 0 && req_d[idx]) begin
                        owner[k] = idx; sel_m[k] = idx; beats[k] = 0;
                        if (k == 0) $display("grant a: req=%b -> requester %0d", req_d, idx);
                    end
                end
            end else begin
                bit xfer;
                xfer = req_d[owner[k]] && rdy_d;
                if (xfer) beats[k]++;
                if ((xfer && beats[k] == mb[k]) || !req_d[owner[k]]) begin
                    ptr_m[k] = (owner[k] + 1) % 4;
                    owner[k] = -1;
                end
            end
        end
        if (rst) model_ok = 1'b1;
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic rdy);
        logic [3:0] g_gnt [2];
        logic [1:0] g_sel [2];
        logic       g_en  [2];
        logic [7:0] g_s   [2];
        logic       g_sv  [2];
        @(negedge clk);
        rst = r; req_d = rq; rdy_d = rdy;
        for (int i = 0; i < 4; i++) e_d[i] = 8'($urandom);
        #1;
        g_gnt[0] = bus_a.gnt; g_sel[0] = bus_a.sel; g_en[0] = bus_a.en; g_s[0] = bus_a.s; g_sv[0] = bus_a.s_valid;
        g_gnt[1] = bus_b.gnt; g_sel[1] = bus_b.sel; g_en[1] = bus_b.en; g_s[1] = bus_b.s; g_sv[1] = bus_b.s_valid;
        last_gnt_a = bus_a.gnt;
        if (model_ok) begin
            for (int k = 0; k < 2; k++) begin
                bit busy;
                busy = owner[k] >= 0;
                check($sformatf("gnt[%0d]", k), 32'(g_gnt[k]), busy ? 32'(1 << sel_m[k]) : 32'd0);
                check($sformatf("sel[%0d]", k), 32'(g_sel[k]), 32'(sel_m[k]));
                check($sformatf("en[%0d]", k), 32'(g_en[k]), 32'(busy));
                check($sformatf("s[%0d]", k), 32'(g_s[k]), busy ? 32'(e_d[sel_m[k]]) : 32'd0);
                check($sformatf("s_valid[%0d]", k), 32'(g_sv[k]), 32'(busy && req_d[sel_m[k]]));
                check($sformatf("gnt_onehot0[%0d]", k), 32'($onehot0(g_gnt[k])), 32'd1);
            end
        end
        @(posedge clk);
        model_step();
    endtask

    initial begin
        logic [3:0] rq;
        mb[0] = 4; mb[1] = 1;
        for (int k = 0; k < 2; k++) begin
            owner[k] = -1; ptr_m[k] = 0; sel_m[k] = 0; beats[k] = 0;
        end
        for (int i = 0; i < 4; i++) e_d[i] = '0;
        exp029 = '{4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000};

        // Reset, then 1010 held: grant 1 for four beats, one bubble, then grant 3.
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b0, 4'b1010, 1'b1);
            check($sformatf("req029_gnt_seq%0d", i), 32'(last_gnt_a), 32'(exp029[i]));
        end

        // All requesting: round-robin order with pointer wrap.
        step(1'b1, 4'b0000, 1'b0);
        repeat (30) step(1'b0, 4'b1111, 1'b1);

        // Requester 2 drops after two transfers, next grant goes to 3.
        step(1'b1, 4'b0000, 1'b0);
        repeat (3) step(1'b0, 4'b0100, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        repeat (4) step(1'b0, 4'b1111, 1'b1);

        // Downstream stall on requester 0.
        step(1'b1, 4'b0000, 1'b0);
        repeat (11) step(1'b0, 4'b0001, 1'b0);
        repeat (6) step(1'b0, 4'b0001, 1'b1);

        // Reset mid-burst on requester 3, then re-grant from ptr 0.
        step(1'b1, 4'b0000, 1'b0);
        repeat (2) step(1'b0, 4'b1000, 1'b1);
        step(1'b1, 4'b1000, 1'b1);
        step(1'b0, 4'b0000, 1'b1);
        repeat (4) step(1'b0, 4'b1000, 1'b1);

        // Randomized traffic with sticky requests, stalls and rare resets.
        rq = 4'($urandom);
        for (int n = 0; n < 600; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(7) == 0) rq[b] = ~rq[b];
            step(($urandom_range(99) == 0), rq, ($urandom_range(3) != 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mux4_arb.md
MUX4_ARB -- requirements
Module: mux4_arb

Interface
REQ-001 Parameter WIDTH, default 8, data width of every requester input and of output s.
REQ-002 Parameter MAX_BURST, default 4, maximum accepted beats per grant; legal range 1..255.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous reset, active-high, sampled on rising edge of clk.
REQ-005 req  input  4  per-requester request, bit i belongs to requester i; held high while requester has data.
REQ-006 e0, e1, e2, e3  input  WIDTH each  requester data words, valid only while corresponding req bit is high.
REQ-007 s_ready  input  1  downstream ready; a beat transfers when s_valid and s_ready are both high on a rising edge.
REQ-008 gnt  output  4  one-hot grant, all-zero when idle.
REQ-009 sel  output  2  index of granted requester, registered.
REQ-010 en  output  1  mux enable, high exactly while in BUSY.
REQ-011 s  output  WIDTH  selected data word; zero when en is low.
REQ-012 s_valid  output  1  en AND req[sel]; combinational from registered sel/en and live req.

Function
REQ-013 The FSM SHALL have two states: IDLE and BUSY.
REQ-014 In IDLE with req != 0, the block SHALL select the first requester with req high, searching ptr, ptr+1, ... modulo 4, and SHALL load sel, set gnt[sel], set en, and enter BUSY on the same edge.
REQ-015 Grant latency SHALL be one cycle: req sampled high at edge N gives gnt/en high from edge N to N+1.
REQ-016 In IDLE with req == 0, outputs SHALL stay at idle values (gnt=0, en=0, s=0, s_valid=0); sel and ptr SHALL hold.
REQ-017 In BUSY, s SHALL equal e[sel] combinationally; sel SHALL NOT change.
REQ-018 Each transfer SHALL increment an 8-bit beat counter. The counter SHALL clear on entry to BUSY.
REQ-019 BUSY SHALL end on the edge where either a transfer occurs with beat count equal to MAX_BURST-1, or req[sel] is sampled low; the first condition takes priority when both hold.
REQ-020 On release, the block SHALL set ptr = sel+1 modulo 4 (3 wraps to 0), clear gnt and en, and return to IDLE.
REQ-021 Every grant SHALL be followed by at least one IDLE cycle (arbitration bubble); back-to-back grants SHALL be impossible.
REQ-022 Requests from other requesters during BUSY SHALL NOT affect the current grant.
REQ-023 With s_ready held low, BUSY SHALL persist indefinitely while req[sel] stays high.
REQ-024 gnt SHALL be one-hot or zero at all times.

Reset
REQ-025 While rst is high at an edge, the block SHALL force state=IDLE, ptr=0, sel=0, gnt=0, en=0, beat count=0; s=0 and s_valid=0 follow.
REQ-026 Reset SHALL abort any in-progress burst with no completion beat. The first grant after reset SHALL use ptr=0.

Structure
REQ-027 State encodings (IDLE=0, BUSY=1), NUM_REQ=4 and SEL_W=2 SHALL live in a shared package mux_arb_pkg.
REQ-028 The data path SHALL be one instance of the existing sub-module mux4 (en, sel, e0..e3 -> s). The FSM, pointer and counter SHALL be local to mux4_arb.

Verification
REQ-029 Reset then req=4'b1010, s_ready=1, MAX_BURST=4, both held -> gnt=4'b0010 one cycle later; 4 beats of e1; 1 IDLE cycle; then gnt=4'b1000.
REQ-030 All req=4'b1111, s_ready=1, bursts held -> grant order 0,1,2,3,0; ptr wraps 3->0.
REQ-031 Grant on requester 2, req[2] drops after 2 transfers -> release on that edge; ptr=3; total beats=2.
REQ-032 Grant on requester 0, s_ready=0 for 10 cycles, then 1 -> gnt stays 4'b0001, s_valid=1 throughout, no beat counted until s_ready=1.
REQ-033 rst asserted mid-burst on requester 3 (after 1 beat) -> next edge gnt=0, en=0, s=0; with req=4'b1000 after release, grant to 3 (ptr restarted at 0).
REQ-034 MAX_BURST=1, req=4'b0001 held, s_ready=1 -> alternating gnt=4'b0001 / IDLE every cycle, one beat per grant; assertion: gnt never multi-hot.
